merge_reg_arbiter: RTL and testbench
====================================

MERGE_REG_ARBITER -- requirements
Module: merge_reg_arbiter

Interface
REQ-001 Parameter C_ADDR_WIDTH, default 4: byte-address width of the merge IP register space (four 32-bit registers at 0x0, 0x4, 0x8, 0xC).
REQ-002 Parameter C_DATA_WIDTH, default 32: register data width; the only supported value is 32.
REQ-003 ACLK  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester access request, bit i = requester i.
REQ-006 req_ready  out  2  per-requester accept strobe.
REQ-007 req_we  in  2  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  in  2*C_ADDR_WIDTH  per-requester byte address; slice i is requester i.
REQ-009 req_wdata  in  2*C_DATA_WIDTH  per-requester write data.
REQ-010 rsp_valid  out  2  one-cycle completion pulse to the granted requester.
REQ-011 rsp_rdata  out  C_DATA_WIDTH  read data, shared by both requesters and qualified by rsp_valid.
REQ-012 rsp_resp  out  2  AXI response code, shared by both requesters and qualified by rsp_valid.
REQ-013 M_AXI_AW* (ADDR, PROT[3], VALID out; READY in), W* (DATA, STRB[4], VALID out; READY in), B* (RESP[2], VALID in; READY out), AR* (ADDR, PROT, VALID out; READY in) and R* (DATA, RESP, VALID in; READY out) SHALL form an AXI4-Lite master port.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, WRITE, WRESP, RADDR and RDATA.
REQ-015 In IDLE, arbitration SHALL be round-robin using last_grant; a requester i with req_valid[i]=1 wins if it is the only one valid, or if both are valid and i != last_grant.
REQ-016 req_ready[i] SHALL be combinational and high only while in IDLE and i is the winner; a handshake is req_valid[i] & req_ready[i].
REQ-017 On a handshake the block SHALL register grant, we, addr (with bits [1:0] forced to 0) and wdata, and SHALL set last_grant := grant.
REQ-018 On a handshake the block SHALL go to WRITE when we=1 and to RADDR when we=0.
REQ-019 In WRITE, AWVALID and WVALID SHALL both be asserted in the entry cycle.
REQ-020 In WRITE, AWVALID and WVALID SHALL each drop independently on their own handshake; the two may complete in the same cycle or in either order.
REQ-021 WRITE SHALL go to WRESP once both the AW and W handshakes have completed.
REQ-022 In WRESP, BREADY SHALL be 1; when BVALID=1 the block SHALL capture BRESP and go to IDLE.
REQ-023 In RADDR, ARVALID SHALL be 1 until ARREADY=1, then the block SHALL go to RDATA.
REQ-024 In RDATA, RREADY SHALL be 1; when RVALID=1 the block SHALL capture RDATA and RRESP and go to IDLE.
REQ-025 rsp_valid[grant] SHALL pulse high for exactly one cycle in the cycle after the B or R handshake, with rsp_rdata and rsp_resp valid in that cycle.
REQ-026 rsp_rdata SHALL be 0 for writes.
REQ-027 The response path SHALL have no backpressure; requesters must accept the rsp_valid pulse.
REQ-028 A new request SHALL be accepted in the same cycle that rsp_valid pulses.
REQ-029 WSTRB SHALL be 4'hF and AWPROT/ARPROT SHALL be 3'b000.
REQ-030 With zero-wait-state slave readies, latency from handshake (cycle 0) to rsp_valid SHALL be 3 cycles for both writes and reads.
REQ-031 A requester dropping req_valid before its handshake SHALL cause no transaction and SHALL leave last_grant unchanged.
REQ-032 Exactly one AXI transaction SHALL be outstanding at a time; AR and AW SHALL never be valid together.
REQ-033 A BRESP or RRESP of SLVERR or DECERR SHALL be forwarded unchanged on rsp_resp, and the FSM SHALL return to IDLE normally.

Reset
REQ-034 While ARESET=1, the FSM SHALL be in IDLE and last_grant SHALL be 1, so that requester 0 wins the first tie.
REQ-035 While ARESET=1, every VALID/READY output, rsp_valid, rsp_rdata and rsp_resp SHALL be 0, as SHALL the registered address and data.
REQ-036 A reset asserted mid-transaction SHALL abort it immediately with no rsp_valid; the aborted transaction SHALL not be re-issued after release.

Verification
REQ-037 Requester 0 writes 0x00000001 to 0x0 with zero-wait slave -> AWADDR=0x0, WDATA=0x00000001, WSTRB=0xF, rsp_valid[0] exactly 3 cycles after handshake, rsp_resp=0.
REQ-038 Both requesters valid every cycle for 4 transactions after reset -> grants occur in the order 0, 1, 0, 1.
REQ-039 Write 0x1..0x4 to 0x0, 0x4, 0x8, 0xC, then read them back -> rsp_rdata returns 0x1, 0x2, 0x3, 0x4 with rsp_resp=0.
REQ-040 Slave delays WREADY 3 cycles after AWREADY -> AWVALID drops after 1 cycle, WVALID holds 4 cycles, exactly one B handshake, one rsp_valid.
REQ-041 Read of 0xD with RRESP=2'b10 -> ARADDR=0xC, rsp_resp=2'b10, FSM back in IDLE.
REQ-042 ARESET pulsed during RDATA -> rsp_valid stays 0, ARVALID and RREADY are 0 after reset, the next tie is granted to requester 0.

Source files
------------

// File: rtl/merge_reg_arbiter_if.sv
// Requester-side and AXI4-Lite master-side signal bundle for merge_reg_arbiter.
// master = arbiter view (drives req_ready, rsp_*, AXI master outputs); slave = environment view.
interface merge_reg_arbiter_if #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
);
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [1:0]                req_we;
    logic [2*C_ADDR_WIDTH-1:0] req_addr;
    logic [2*C_DATA_WIDTH-1:0] req_wdata;
    logic [1:0]                rsp_valid;
    logic [C_DATA_WIDTH-1:0]   rsp_rdata;
    logic [1:0]                rsp_resp;

    logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]                M_AXI_AWPROT;
    logic                      M_AXI_AWVALID;
    logic                      M_AXI_AWREADY;
    logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [3:0]                M_AXI_WSTRB;
    logic                      M_AXI_WVALID;
    logic                      M_AXI_WREADY;
    logic [1:0]                M_AXI_BRESP;
    logic                      M_AXI_BVALID;
    logic                      M_AXI_BREADY;
    logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]                M_AXI_ARPROT;
    logic                      M_AXI_ARVALID;
    logic                      M_AXI_ARREADY;
    logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]                M_AXI_RRESP;
    logic                      M_AXI_RVALID;
    logic                      M_AXI_RREADY;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/merge_reg_arbiter.sv
// Two-requester round-robin arbiter onto one AXI4-Lite master (one transaction at a time).
// Ports: ACLK, ARESET (async, active-high), bus (merge_reg_arbiter_if.master: req/rsp + M_AXI_*).
module merge_reg_arbiter #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    merge_reg_arbiter_if.master bus
);
    localparam int AW = C_ADDR_WIDTH;
    localparam int DW = C_DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

    state_t          state, state_nxt;
    logic            last_grant;
    logic            grant;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            aw_done, w_done;
    logic [1:0]      rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic [1:0]      rsp_resp_q;

    logic [1:0]      win;
    logic            sel;
    logic            hs;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        win[0] = bus.req_valid[0] & (~bus.req_valid[1] | last_grant);
        win[1] = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
    end

    assign sel       = win[1];
    assign sel_we    = sel ? bus.req_we[1] : bus.req_we[0];
    assign sel_addr  = sel ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
    assign sel_wdata = sel ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];

    assign bus.req_ready = (state == IDLE && !ARESET) ? win : 2'b00;
    assign hs            = |(bus.req_valid & bus.req_ready);

    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_AWVALID = (state == WRITE) && !aw_done;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = 4'hF;
    assign bus.M_AXI_WVALID  = (state == WRITE) && !w_done;
    assign bus.M_AXI_BREADY  = (state == WRESP);
    assign bus.M_AXI_ARADDR  = addr_q;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_ARVALID = (state == RADDR);
    assign bus.M_AXI_RREADY  = (state == RDATA);

    assign aw_hs = bus.M_AXI_AWVALID & bus.M_AXI_AWREADY;
    assign w_hs  = bus.M_AXI_WVALID & bus.M_AXI_WREADY;
    assign b_hs  = bus.M_AXI_BREADY & bus.M_AXI_BVALID;
    assign ar_hs = bus.M_AXI_ARVALID & bus.M_AXI_ARREADY;
    assign r_hs  = bus.M_AXI_RREADY & bus.M_AXI_RVALID;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_resp  = rsp_resp_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (hs) state_nxt = sel_we ? WRITE : RADDR;
            // AW and W may finish in either order; leave once both are done.
            WRITE:   if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WRESP;
            WRESP:   if (b_hs) state_nxt = IDLE;
            RADDR:   if (ar_hs) state_nxt = RDATA;
            RDATA:   if (r_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= 2'b00;
            if (hs) begin
                grant      <= sel;
                last_grant <= sel;
                addr_q     <= {sel_addr[AW-1:2], 2'b00};
                wdata_q    <= sel_wdata;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (b_hs) begin
                rsp_valid_q <= grant ? 2'b10 : 2'b01;
                rsp_rdata_q <= '0;
                rsp_resp_q  <= bus.M_AXI_BRESP;
            end
            if (r_hs) begin
                rsp_valid_q <= grant ? 2'b10 : 2'b01;
                rsp_rdata_q <= bus.M_AXI_RDATA;
                rsp_resp_q  <= bus.M_AXI_RRESP;
            end
        end
    end
endmodule

// File: tb/tb_merge_reg_arbiter.sv
// Self-checking bench for merge_reg_arbiter: vector table, corner sequences, random traffic.
// An AXI4-Lite slave with programmable delays/responses is modelled inside the bench.
module tb_merge_reg_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    merge_reg_arbiter_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

    merge_reg_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // slave model configuration and state
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] smem [4];
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, b_pend, r_pend;
    logic [3:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_awprot, s_arprot;
    logic        p_awv, p_wv, p_bv, p_br, p_arv, p_rv, p_rr;
    logic [3:0]  p_awaddr, p_araddr, p_wstrb;
    logic [31:0] p_wdata;
    logic [2:0]  p_awprot, p_arprot;

    // monitors
    int mon_awv, mon_wv, mon_b, mon_rsp, mon_arv, both_err;

    // reference model
    logic [31:0] ref_mem [4];
    int          model_last;

    function automatic int rr_win(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    // One clock: wait for the falling edge, account for handshakes of the
    // preceding rising edge, then drive the slave outputs for the next one.
    task automatic tick();
        @(negedge ACLK);
        if (bus.M_AXI_AWVALID && bus.M_AXI_ARVALID) both_err++;
        if (bus.M_AXI_AWVALID) mon_awv++;
        if (bus.M_AXI_WVALID) mon_wv++;
        if (bus.M_AXI_ARVALID) mon_arv++;
        if (bus.rsp_valid != 2'b00) mon_rsp++;
        if (ARESET) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
            bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
            bus.M_AXI_RVALID = 0; bus.M_AXI_RRESP = 0; bus.M_AXI_RDATA = 0;
            p_awv = 0; p_wv = 0; p_bv = 0; p_br = 0; p_arv = 0; p_rv = 0; p_rr = 0;
        end else begin
            if (p_awv && bus.M_AXI_AWREADY) begin
                s_awaddr = p_awaddr; s_awprot = p_awprot; aw_got = 1;
            end
            if (p_wv && bus.M_AXI_WREADY) begin
                s_wdata = p_wdata; s_wstrb = p_wstrb; w_got = 1;
            end
            if (aw_got && w_got) begin
                smem[s_awaddr[3:2]] = s_wdata;
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            if (p_bv && p_br) begin
                b_pend = 0; mon_b++;
            end
            if (p_arv && bus.M_AXI_ARREADY) begin
                s_araddr = p_araddr; s_arprot = p_arprot; r_pend = 1; r_cnt = 0;
            end
            if (p_rv && p_rr) r_pend = 0;

            if (bus.M_AXI_AWVALID) begin
                bus.M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++;
            end else begin
                bus.M_AXI_AWREADY = 0; aw_cnt = 0;
            end
            if (bus.M_AXI_WVALID) begin
                bus.M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++;
            end else begin
                bus.M_AXI_WREADY = 0; w_cnt = 0;
            end
            if (bus.M_AXI_ARVALID) begin
                bus.M_AXI_ARREADY = (ar_cnt >= ar_delay); ar_cnt++;
            end else begin
                bus.M_AXI_ARREADY = 0; ar_cnt = 0;
            end
            if (b_pend) begin
                bus.M_AXI_BVALID = (b_cnt >= b_delay); b_cnt++;
                bus.M_AXI_BRESP = bresp_cfg;
            end else begin
                bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
            end
            if (r_pend) begin
                bus.M_AXI_RVALID = (r_cnt >= r_delay); r_cnt++;
                bus.M_AXI_RDATA = smem[s_araddr[3:2]];
                bus.M_AXI_RRESP = rresp_cfg;
            end else begin
                bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
            end

            p_awv = bus.M_AXI_AWVALID; p_awaddr = bus.M_AXI_AWADDR; p_awprot = bus.M_AXI_AWPROT;
            p_wv = bus.M_AXI_WVALID; p_wdata = bus.M_AXI_WDATA; p_wstrb = bus.M_AXI_WSTRB;
            p_arv = bus.M_AXI_ARVALID; p_araddr = bus.M_AXI_ARADDR; p_arprot = bus.M_AXI_ARPROT;
            p_bv = bus.M_AXI_BVALID; p_br = bus.M_AXI_BREADY;
            p_rv = bus.M_AXI_RVALID; p_rr = bus.M_AXI_RREADY;
        end
    endtask

    task automatic set_req(input int r, input logic we, input logic [3:0] a, input logic [31:0] d);
        bus.req_we[r] = we;
        bus.req_addr[r*4 +: 4] = a;
        bus.req_wdata[r*32 +: 32] = d;
    endtask

    task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
        aw_delay = a; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    // Issue one arbitration round with valid pattern v and follow it to its response.
    task automatic txn(input string tag, input logic [1:0] v, output int w, output int lat,
                       output logic [31:0] rdata, output logic [1:0] resp);
        int          n;
        logic        we;
        logic [3:0]  a;
        logic [31:0] d;
        logic [1:0]  exp_oh;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rs;
        bus.req_valid = v;
        #1;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        w = rr_win(v, model_last);
        exp_oh = (w == 1) ? 2'b10 : 2'b01;
        check({tag, "_grant"}, bus.req_ready, exp_oh);
        model_last = w;
        we = bus.req_we[w];
        a = bus.req_addr[w*4 +: 4];
        d = bus.req_wdata[w*32 +: 32];
        exp_rd = we ? 32'h0 : ref_mem[a[3:2]];
        exp_rs = we ? bresp_cfg : rresp_cfg;
        tick();
        bus.req_valid = 2'b00;
        lat = 1;
        while (bus.rsp_valid == 2'b00 && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_rsp_who"}, bus.rsp_valid, exp_oh);
        rdata = bus.rsp_rdata;
        resp = bus.rsp_resp;
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_resp"}, resp, exp_rs);
        if (we) begin
            check({tag, "_awaddr"}, s_awaddr, {a[3:2], 2'b00});
            check({tag, "_wdata"}, s_wdata, d);
            check({tag, "_wstrb"}, s_wstrb, 4'hF);
            check({tag, "_awprot"}, s_awprot, 3'b000);
            ref_mem[a[3:2]] = d;
        end else begin
            check({tag, "_araddr"}, s_araddr, {a[3:2], 2'b00});
            check({tag, "_arprot"}, s_arprot, 3'b000);
        end
        tick();
        check({tag, "_pulse_len"}, bus.rsp_valid, 2'b00);
    endtask

    typedef struct {
        int          r;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [3:0]  exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, lat, n, ng;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [3:0]  gbits;

        tbl[0] = '{0, 1'b1, 4'h0, 32'h0000_0001, 2'b00, 4'h0, 32'h0};
        tbl[1] = '{1, 1'b1, 4'h4, 32'h0000_0002, 2'b00, 4'h4, 32'h0};
        tbl[2] = '{0, 1'b1, 4'h8, 32'h0000_0003, 2'b00, 4'h8, 32'h0};
        tbl[3] = '{1, 1'b1, 4'hC, 32'h0000_0004, 2'b00, 4'hC, 32'h0};
        tbl[4] = '{0, 1'b0, 4'h0, 32'h0, 2'b00, 4'h0, 32'h0000_0001};
        tbl[5] = '{1, 1'b0, 4'h4, 32'h0, 2'b00, 4'h4, 32'h0000_0002};
        tbl[6] = '{0, 1'b0, 4'h8, 32'h0, 2'b00, 4'h8, 32'h0000_0003};
        tbl[7] = '{1, 1'b0, 4'hC, 32'h0, 2'b00, 4'hC, 32'h0000_0004};
        tbl[8] = '{0, 1'b0, 4'hD, 32'h0, 2'b10, 4'hC, 32'h0000_0004};
        tbl[9] = '{1, 1'b1, 4'h6, 32'h0000_0055, 2'b11, 4'h4, 32'h0};

        for (int i = 0; i < 4; i++) begin
            smem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mon_awv = 0; mon_wv = 0; mon_b = 0; mon_rsp = 0; mon_arv = 0; both_err = 0;
        set_delays(0, 0, 0, 0, 0);
        bresp_cfg = 0; rresp_cfg = 0;
        s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0; s_awprot = 0; s_arprot = 0;
        bus.req_valid = 2'b11; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
        bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
        bus.M_AXI_RVALID = 0; bus.M_AXI_RRESP = 0; bus.M_AXI_RDATA = 0;
        model_last = 1;

        // reset state
        tick();
        tick();
        check("rst_axi_valid_ready",
              {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
               bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 5'b0);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_resp", bus.rsp_resp, 2'b00);
        check("rst_addr", bus.M_AXI_AWADDR, 4'h0);
        check("rst_wdata", bus.M_AXI_WDATA, 32'h0);
        bus.req_valid = 2'b00;
        ARESET = 1'b0;
        tick();

        // vector table, zero-wait slave
        for (int i = 0; i < 10; i++) begin
            set_delays(0, 0, 0, 0, 0);
            bresp_cfg = tbl[i].resp;
            rresp_cfg = tbl[i].resp;
            set_req(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            txn($sformatf("vec%0d", i), (tbl[i].r == 1) ? 2'b10 : 2'b01, w, lat, rd, rs);
            check($sformatf("vec%0d_lat", i), lat, 3);
            check($sformatf("vec%0d_tbl_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("vec%0d_tbl_resp", i), rs, tbl[i].resp);
            check($sformatf("vec%0d_tbl_addr", i), tbl[i].we ? s_awaddr : s_araddr,
                  tbl[i].exp_addr);
        end
        check("vec_idle_after_err", bus.M_AXI_AWVALID | bus.M_AXI_ARVALID, 1'b0);

        // round robin with both requesters valid every cycle after reset
        bresp_cfg = 0; rresp_cfg = 0;
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        model_last = 1;
        set_req(0, 1'b1, 4'h0, 32'h0000_00A0);
        set_req(1, 1'b1, 4'h4, 32'h0000_00B1);
        bus.req_valid = 2'b11;
        #1;
        ng = 0; n = 0; gbits = 4'b0;
        while (ng < 4 && n < 100) begin
            if (bus.req_ready != 2'b00) begin
                w = rr_win(2'b11, model_last);
                check($sformatf("rr_grant%0d", ng), bus.req_ready, (w == 1) ? 2'b10 : 2'b01);
                if (ng > 0) check($sformatf("rr_accept_on_rsp%0d", ng), bus.rsp_valid != 2'b00, 1'b1);
                gbits[ng] = (bus.req_ready == 2'b10);
                ref_mem[w] = (w == 1) ? 32'h0000_00B1 : 32'h0000_00A0;
                model_last = w;
                ng++;
            end
            tick();
            n++;
        end
        bus.req_valid = 2'b00;
        check("rr_count", ng, 4);
        check("rr_order", gbits, 4'b1010);
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        tick();

        // W accepted three cycles after AW
        set_delays(0, 3, 0, 0, 0);
        mon_awv = 0; mon_wv = 0; mon_b = 0; mon_rsp = 0;
        set_req(0, 1'b1, 4'h8, 32'hCAFE_0008);
        txn("wdly", 2'b01, w, lat, rd, rs);
        check("wdly_awvalid_cycles", mon_awv, 1);
        check("wdly_wvalid_cycles", mon_wv, 4);
        check("wdly_b_count", mon_b, 1);
        check("wdly_rsp_count", mon_rsp, 1);
        check("wdly_lat", lat, 6);

        // reset in RDATA aborts the read
        set_delays(0, 0, 0, 0, 6);
        set_req(0, 1'b0, 4'h4, 32'h0);
        bus.req_valid = 2'b01;
        #1;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("abort_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        n = 0;
        while (!bus.M_AXI_RREADY && n < 20) begin
            tick();
            n++;
        end
        check("abort_in_rdata", bus.M_AXI_RREADY, 1'b1);
        mon_rsp = 0;
        ARESET = 1'b1;
        #1;
        check("abort_arvalid", bus.M_AXI_ARVALID, 1'b0);
        check("abort_rready", bus.M_AXI_RREADY, 1'b0);
        check("abort_rsp", bus.rsp_valid, 2'b00);
        tick();
        tick();
        ARESET = 1'b0;
        model_last = 1;
        mon_arv = 0;
        repeat (8) tick();
        check("abort_no_rsp", mon_rsp, 0);
        check("abort_no_reissue", mon_arv, 0);
        set_delays(0, 0, 0, 0, 0);
        set_req(0, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b0, 4'h4, 32'h0);
        txn("after_rst", 2'b11, w, lat, rd, rs);
        check("after_rst_tie_winner", w, 0);

        // random traffic against the model
        for (int k = 0; k < 40; k++) begin
            set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            bresp_cfg = 2'($urandom_range(0, 3));
            rresp_cfg = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++)
                set_req(r, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            txn($sformatf("rnd%0d", k), 2'($urandom_range(1, 3)), w, lat, rd, rs);
        end

        check("aw_ar_overlap", both_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
